// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the UART packet deframer.
package uart_pkt_pkg;

   typedef enum logic [2:0] {
      StHunt,
      StType,
      StLenHi,
      StLenLo,
      StPayload,
      StCrcHi,
      StCrcLo,
      StFlush
   } state_e;

   localparam logic [2:0] ErrTimeout   = 3'd0;
   localparam logic [2:0] ErrBadLen    = 3'd1;
   localparam logic [2:0] ErrOverflow  = 3'd2;
   localparam logic [2:0] ErrCrc       = 3'd3;
   localparam logic [2:0] ErrFlushDrop = 3'd4;

   localparam logic [7:0] SyncByteDefault = 8'h5A;

   // CRC-16/CCITT-FALSE, MSB first, one byte per call
   function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc,
                                                    input logic [7:0]  data);
      logic [15:0] c;
      c = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/uart_pkt_packer.sv
// Packs payload bytes into DATA_WIDTH beats and owns the AXI-Stream output register.
module uart_pkt_packer
   import uart_pkt_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    byte_we_i,
   input  logic [7:0]              byte_i,
   input  logic                    byte_last_i,
   input  logic [7:0]              pkt_type_i,
   input  logic                    flush_req_i,
   input  logic                    flush_bad_i,
   output logic                    ovf_o,
   output logic                    flush_done_o,
   output logic [DATA_WIDTH-1:0]   m_tdata_o,
   output logic [DATA_WIDTH/8-1:0] m_tkeep_o,
   output logic                    m_tvalid_o,
   input  logic                    m_tready_i,
   output logic                    m_tlast_o,
   output logic [8:0]              m_tuser_o
);

   localparam int unsigned Bytes = DATA_WIDTH / 8;
   localparam int unsigned LaneW = (Bytes > 1) ? $clog2(Bytes) : 1;

   logic [DATA_WIDTH-1:0] pack_data_q, pack_data_d, out_data_q, out_data_d;
   logic [Bytes-1:0]      pack_keep_q, pack_keep_d, out_keep_q, out_keep_d;
   logic [LaneW-1:0]      lane_q, lane_d;
   logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [8:0]            out_user_q, out_user_d;
   logic                  out_free, lane_full, push;

   // Output register can take a new beat when empty or being drained this cycle
   assign out_free     = !out_valid_q || m_tready_i;
   assign lane_full    = (lane_q == LaneW'(Bytes - 1));
   // A full chunk that is not the last one of the packet must leave the pack register
   assign push         = byte_we_i && lane_full && !byte_last_i;
   assign ovf_o        = push && !out_free;
   assign flush_done_o = flush_req_i && out_free;

   // Next-state for pack lanes and output register
   always_comb begin
      pack_data_d = pack_data_q;
      pack_keep_d = pack_keep_q;
      lane_d      = lane_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_user_d  = out_user_q;
      if (out_valid_q && m_tready_i) begin
         out_valid_d = 1'b0;
      end
      if (byte_we_i) begin
         pack_data_d[{lane_q, 3'b000} +: 8] = byte_i;
         pack_keep_d[lane_q]                = 1'b1;
         lane_d = lane_full ? '0 : lane_q + LaneW'(1);
         // On overflow the full chunk stays put; the top stops writing afterwards
         if (push && out_free) begin
            out_data_d  = pack_data_d;
            out_keep_d  = pack_keep_d;
            out_last_d  = 1'b0;
            out_user_d  = {1'b0, pkt_type_i};
            out_valid_d = 1'b1;
            pack_data_d = '0;
            pack_keep_d = '0;
         end
      end
      if (flush_done_o) begin
         out_data_d  = pack_data_q;
         out_keep_d  = pack_keep_q;
         out_last_d  = 1'b1;
         out_user_d  = {flush_bad_i, pkt_type_i};
         out_valid_d = 1'b1;
         pack_data_d = '0;
         pack_keep_d = '0;
         lane_d      = '0;
      end
   end

   // Pack and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pack_data_q <= '0;
         pack_keep_q <= '0;
         lane_q      <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_user_q  <= '0;
      end else begin
         pack_data_q <= pack_data_d;
         pack_keep_q <= pack_keep_d;
         lane_q      <= lane_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_user_q  <= out_user_d;
      end
   end

   assign m_tdata_o  = out_data_q;
   assign m_tkeep_o  = out_keep_q;
   assign m_tvalid_o = out_valid_q;
   assign m_tlast_o  = out_last_q;
   assign m_tuser_o  = out_user_q;

endmodule

// File: rtl/uart_pkt_deframer.sv
// UART packet deframer: sync hunt, header parse, payload packing, abort handling.
// Define UART_PKT_CRC_EN to check the trailing CRC-16/CCITT-FALSE.
module uart_pkt_deframer
   import uart_pkt_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned MAX_LEN        = 1536,
   parameter logic [7:0]  SYNC_BYTE      = SyncByteDefault,
   parameter int unsigned TIMEOUT_CYCLES = 8680
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic [DATA_WIDTH-1:0]   m_tdata,
   output logic [DATA_WIDTH/8-1:0] m_tkeep,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic                    m_tlast,
   output logic [8:0]              m_tuser,
   output logic                    pkt_ok,
   output logic                    err_valid,
   output logic [2:0]              err_code
);

   localparam int unsigned IdleW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [15:0] MaxLen = 16'(MAX_LEN);

   state_e            state_q, state_d;
   logic [7:0]        type_q, type_d, len_hi_q, len_hi_d;
   logic [15:0]       rem_q, rem_d, len_rx;
   logic              bad_q, bad_d;
   logic [IdleW-1:0]  idle_q, idle_d;
   logic              store, flush_req, flush_bad, flush_done, ovf, timeout, crc_fail;

   assign len_rx  = {len_hi_q, rx_data};
   assign timeout = !rx_valid && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));

   // Idle counter only runs while a packet is being received
   always_comb begin
      if (state_q == StHunt || state_q == StFlush || rx_valid) begin
         idle_d = '0;
      end else begin
         idle_d = idle_q + IdleW'(1);
      end
   end

`ifdef UART_PKT_CRC_EN
   logic [15:0] crc_q, crc_d;
   logic [7:0]  crc_hi_q, crc_hi_d;

   // Running CRC over type, length and payload; every hunted byte re-seeds it
   always_comb begin
      crc_d    = crc_q;
      crc_hi_d = crc_hi_q;
      if (rx_valid) begin
         case (state_q)
            StHunt:                               crc_d    = 16'hFFFF;
            StType, StLenHi, StLenLo, StPayload:  crc_d    = crc16_ccitt_byte(crc_q, rx_data);
            StCrcHi:                              crc_hi_d = rx_data;
            default:                              ;
         endcase
      end
   end

   // CRC registers
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q    <= '0;
         crc_hi_q <= '0;
      end else begin
         crc_q    <= crc_d;
         crc_hi_q <= crc_hi_d;
      end
   end

   // Only consulted on the CRC_LO byte
   assign crc_fail = ({crc_hi_q, rx_data} != crc_q);
`else
   assign crc_fail = 1'b0;
`endif

   // Packet FSM next-state and error pulses
   always_comb begin
      state_d   = state_q;
      type_d    = type_q;
      len_hi_d  = len_hi_q;
      rem_d     = rem_q;
      bad_d     = bad_q;
      store     = 1'b0;
      flush_req = 1'b0;
      flush_bad = bad_q;
      err_valid = 1'b0;
      err_code  = ErrTimeout;
      unique case (state_q)
         StHunt: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
               state_d = StType;
               bad_d   = 1'b0;
            end
         end
         StType, StLenHi: begin
            if (rx_valid) begin
               if (state_q == StType) begin
                  type_d  = rx_data;
                  state_d = StLenHi;
               end else begin
                  len_hi_d = rx_data;
                  state_d  = StLenLo;
               end
            end else if (timeout) begin
               err_valid = 1'b1;
               state_d   = StHunt;
            end
         end
         StLenLo: begin
            if (rx_valid) begin
               if (len_rx == 16'd0 || len_rx > MaxLen) begin
                  err_valid = 1'b1;
                  err_code  = ErrBadLen;
                  state_d   = StHunt;
               end else begin
                  rem_d   = len_rx;
                  state_d = StPayload;
               end
            end else if (timeout) begin
               err_valid = 1'b1;
               state_d   = StHunt;
            end
         end
         StPayload, StCrcHi, StCrcLo: begin
            if (rx_valid) begin
               if (state_q == StPayload) begin
                  // After an overflow bytes are still counted but no longer stored
                  store = !bad_q;
                  rem_d = rem_q - 16'd1;
                  if (rem_q == 16'd1) begin
                     state_d = StCrcHi;
                  end
                  if (ovf) begin
                     bad_d     = 1'b1;
                     err_valid = 1'b1;
                     err_code  = ErrOverflow;
                  end
               end else if (state_q == StCrcHi) begin
                  state_d = StCrcLo;
               end else begin
                  flush_req = 1'b1;
                  flush_bad = bad_q | crc_fail;
                  bad_d     = flush_bad;
                  if (crc_fail) begin
                     err_valid = 1'b1;
                     err_code  = ErrCrc;
                  end
                  state_d = flush_done ? StHunt : StFlush;
               end
            end else if (timeout) begin
               err_valid = 1'b1;
               flush_req = 1'b1;
               flush_bad = 1'b1;
               bad_d     = 1'b1;
               state_d   = flush_done ? StHunt : StFlush;
            end
         end
         StFlush: begin
            flush_req = 1'b1;
            if (flush_done) begin
               state_d = StHunt;
            end
            if (rx_valid) begin
               err_valid = 1'b1;
               err_code  = ErrFlushDrop;
            end
         end
      endcase
   end

   // FSM and header registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StHunt;
         type_q   <= '0;
         len_hi_q <= '0;
         rem_q    <= '0;
         bad_q    <= 1'b0;
         idle_q   <= '0;
      end else begin
         state_q  <= state_d;
         type_q   <= type_d;
         len_hi_q <= len_hi_d;
         rem_q    <= rem_d;
         bad_q    <= bad_d;
         idle_q   <= idle_d;
      end
   end

   uart_pkt_packer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_packer (
      .clk_i        (clk),
      .rst_i        (rst),
      .byte_we_i    (store),
      .byte_i       (rx_data),
      .byte_last_i  (rem_q == 16'd1),
      .pkt_type_i   (type_q),
      .flush_req_i  (flush_req),
      .flush_bad_i  (flush_bad),
      .ovf_o        (ovf),
      .flush_done_o (flush_done),
      .m_tdata_o    (m_tdata),
      .m_tkeep_o    (m_tkeep),
      .m_tvalid_o   (m_tvalid),
      .m_tready_i   (m_tready),
      .m_tlast_o    (m_tlast),
      .m_tuser_o    (m_tuser)
   );

   assign pkt_ok = m_tvalid && m_tready && m_tlast && !m_tuser[8];

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Randomised bench for uart_pkt_deframer with a queue-based packet model.
module tb_uart_pkt_deframer;

   localparam int unsigned DW  = 64;
   localparam int unsigned TO  = 60;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic [8:0]  user;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic [DW-1:0] m_tdata;
   logic [7:0]    m_tkeep;
   logic          m_tvalid, m_tready, m_tlast, pkt_ok, err_valid;
   logic [8:0]    m_tuser;
   logic [2:0]    err_code;

   int checks = 0, errors = 0, cyc = 0, last_rx_cyc = 0, err_cyc = 0;
   int ok_cnt = 0, exp_ok = 0, stable_viol = 0, tready_mode = 1;
   beat_t obs_q[$], exp_q[$];
   logic [2:0] obs_err[$], exp_err[$];
   logic stall_prev = 1'b0;
   beat_t prev_beat;

   always #5 clk = ~clk;

   uart_pkt_deframer #(
      .DATA_WIDTH     (DW),
      .MAX_LEN        (1536),
      .SYNC_BYTE      (8'h5A),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .m_tdata   (m_tdata),
      .m_tkeep   (m_tkeep),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .m_tuser   (m_tuser),
      .pkt_ok    (pkt_ok),
      .err_valid (err_valid),
      .err_code  (err_code)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: 0 = held low, 1 = held high, other = random with short low runs
   initial begin
      int lows = 0;
      m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tready_mode == 0) m_tready = 1'b0;
         else if (tready_mode == 1) m_tready = 1'b1;
         else if (lows >= 3 || $urandom_range(0, 2) != 0) begin
            m_tready = 1'b1;
            lows = 0;
         end else begin
            m_tready = 1'b0;
            lows++;
         end
      end
   end

   // Monitor: collect transfers, errors, pkt_ok and AXI stability violations
   always @(negedge clk) begin
      beat_t cur;
      cur = '{data: m_tdata, keep: m_tkeep, last: m_tlast, user: m_tuser};
      if (!rst) begin
         if (m_tvalid && m_tready) obs_q.push_back(cur);
         if (err_valid) begin
            obs_err.push_back(err_code);
            err_cyc = cyc;
         end
         if (pkt_ok) ok_cnt++;
         if (rx_valid) last_rx_cyc = cyc;
         if (stall_prev && (!m_tvalid || cur != prev_beat)) stable_viol++;
         stall_prev = m_tvalid && !m_tready;
         prev_beat  = cur;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_crc(input bq_t q);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (q[i]) begin
         c = c ^ {q[i], 8'h00};
         for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   function automatic bq_t rand_payload(input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   function automatic bq_t make_frame(input logic [7:0] typ, input bq_t pl, input logic corrupt);
      bq_t f, body;
      logic [15:0] len, crc;
      len = 16'(pl.size());
      body.push_back(typ);
      body.push_back(len[15:8]);
      body.push_back(len[7:0]);
      foreach (pl[i]) body.push_back(pl[i]);
      crc = 16'h0000;
`ifdef UART_PKT_CRC_EN
      crc = ref_crc(body);
`endif
      if (corrupt) crc = crc ^ 16'h00A5;
      f.push_back(8'h5A);
      foreach (body[i]) f.push_back(body[i]);
      f.push_back(crc[15:8]);
      f.push_back(crc[7:0]);
      return f;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bytes(input bq_t f, input int count);
      for (int i = 0; i < count && i < f.size(); i++) send_byte(f[i], $urandom_range(0, 2));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model: payload split into 8-byte beats, first byte in lane 0
   task automatic expect_beats(input logic [7:0] typ, input bq_t pl, input logic bad);
      int n;
      n = pl.size();
      for (int s = 0; s < n; s += 8) begin
         beat_t b;
         b = '0;
         for (int k = 0; k < 8 && s + k < n; k++) begin
            b.data[k*8 +: 8] = pl[s+k];
            b.keep[k]        = 1'b1;
         end
         b.last = (s + 8 >= n);
         b.user = {b.last && bad, typ};
         exp_q.push_back(b);
      end
   endtask

   task automatic expect_good(input logic [7:0] typ, input bq_t pl, input logic crc_bad);
      expect_beats(typ, pl, crc_bad);
      if (crc_bad) exp_err.push_back(3'd3);
      else exp_ok++;
   endtask

   task automatic clear_all();
      obs_q.delete();
      exp_q.delete();
      obs_err.delete();
      exp_err.delete();
      ok_cnt = 0;
      exp_ok = 0;
   endtask

   task automatic compare(input string name);
      logic [63:0] mask;
      check({name, "_nbeats"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         for (int k = 0; k < 8; k++) mask[k*8 +: 8] = {8{exp_q[i].keep[k]}};
         check($sformatf("%s_data%0d", name, i), obs_q[i].data & mask, exp_q[i].data);
         check($sformatf("%s_keep%0d", name, i), 64'(obs_q[i].keep), 64'(exp_q[i].keep));
         check($sformatf("%s_last%0d", name, i), 64'(obs_q[i].last), 64'(exp_q[i].last));
         check($sformatf("%s_user%0d", name, i), 64'(obs_q[i].user), 64'(exp_q[i].user));
      end
      check({name, "_nerr"}, 64'(obs_err.size()), 64'(exp_err.size()));
      for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++) begin
         check($sformatf("%s_err%0d", name, i), 64'(obs_err[i]), 64'(exp_err[i]));
      end
      check({name, "_pkt_ok"}, 64'(ok_cnt), 64'(exp_ok));
      clear_all();
   endtask

   initial begin
      bq_t pl, f;
      logic [7:0] typ;
      logic [63:0] d0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tdata", m_tdata, 64'h0);
      check("rst_tkeep", 64'(m_tkeep), 64'h0);
      check("rst_tvalid", 64'(m_tvalid), 64'h0);
      check("rst_tlast", 64'(m_tlast), 64'h0);
      check("rst_tuser", 64'(m_tuser), 64'h0);
      check("rst_pkt_ok", 64'(pkt_ok), 64'h0);
      check("rst_err_valid", 64'(err_valid), 64'h0);
      check("rst_err_code", 64'(err_code), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // CONNECT command
      pl = '{8'h00, 8'h01};
      f  = make_frame(8'h01, pl, 1'b0);
      send_bytes(f, f.size());
      idle(10);
      expect_good(8'h01, pl, 1'b0);
      compare("connect");

      // 70-byte frame
      pl = rand_payload(70);
      f  = make_frame(8'h10, pl, 1'b0);
      send_bytes(f, f.size());
      idle(10);
      expect_good(8'h10, pl, 1'b0);
      compare("eth70");

      // Noise before a valid packet
      send_byte(8'h00, 1);
      send_byte(8'hFF, 0);
      send_byte(8'h12, 2);
      typ = 8'($urandom);
      pl  = rand_payload($urandom_range(1, 40));
      f   = make_frame(typ, pl, 1'b0);
      send_bytes(f, f.size());
      idle(10);
      expect_good(typ, pl, 1'b0);
      compare("noise");

      // Bad lengths, then a normal packet
      f = '{8'h5A, 8'h33, 8'h00, 8'h00};
      send_bytes(f, f.size());
      f = '{8'h5A, 8'h33, 8'h06, 8'h01};
      send_bytes(f, f.size());
      idle(5);
      exp_err.push_back(3'd1);
      exp_err.push_back(3'd1);
      compare("badlen");
      pl = rand_payload(13);
      f  = make_frame(8'h44, pl, 1'b0);
      send_bytes(f, f.size());
      idle(10);
      expect_good(8'h44, pl, 1'b0);
      compare("after_badlen");

      // Stall after 10 of 16 payload bytes
      pl = rand_payload(16);
      f  = make_frame(8'h22, pl, 1'b0);
      send_bytes(f, 14);
      idle(TO + 10);
      pl = pl[0:9];
      expect_beats(8'h22, pl, 1'b1);
      exp_err.push_back(3'd0);
      check("stall_to_cycles", 64'(err_cyc - last_rx_cyc), 64'(TO));
      compare("stall");

      // Downstream held off through a 24-byte packet
      tready_mode = 0;
      idle(2);
      pl = rand_payload(24);
      f  = make_frame(8'h31, pl, 1'b0);
      send_bytes(f, f.size());
      idle(4);
      tready_mode = 1;
      idle(10);
      for (int k = 0; k < 8; k++) d0[k*8 +: 8] = pl[k];
      check("ovf_nbeats", 64'(obs_q.size()), 64'd2);
      if (obs_q.size() >= 2) begin
         check("ovf_beat0_data", obs_q[0].data, d0);
         check("ovf_beat0_keep", 64'(obs_q[0].keep), 64'hFF);
         check("ovf_beat0_last", 64'(obs_q[0].last), 64'h0);
         check("ovf_final_last", 64'(obs_q[1].last), 64'h1);
         check("ovf_final_user", 64'(obs_q[1].user), 64'h131);
      end
      check("ovf_nerr", 64'(obs_err.size()), 64'd1);
      if (obs_err.size() >= 1) check("ovf_err0", 64'(obs_err[0]), 64'd2);
      check("ovf_pkt_ok", 64'(ok_cnt), 64'd0);
      clear_all();

      // Corrupted CRC
      pl = rand_payload(20);
      f  = make_frame(8'h55, pl, 1'b1);
      send_bytes(f, f.size());
      idle(10);
`ifdef UART_PKT_CRC_EN
      expect_good(8'h55, pl, 1'b1);
`else
      expect_good(8'h55, pl, 1'b0);
`endif
      compare("crc_corrupt");

      // Byte arriving while the terminating beat waits in FLUSH
      tready_mode = 0;
      idle(2);
      pl = rand_payload(9);
      f  = make_frame(8'h66, pl, 1'b0);
      send_bytes(f, f.size());
      idle(2);
      send_byte(8'h77, 2);
      tready_mode = 1;
      idle(10);
      expect_beats(8'h66, pl, 1'b0);
      exp_err.push_back(3'd4);
      exp_ok = 1;
      compare("flush_drop");

      // Random packets with noise and random backpressure
      tready_mode = 2;
      for (int p = 0; p < 8; p++) begin
         for (int j = $urandom_range(0, 3); j > 0; j--) begin
            logic [7:0] nb;
            nb = 8'($urandom);
            if (nb == 8'h5A) nb = 8'hA5;
            send_byte(nb, $urandom_range(0, 2));
         end
         typ = 8'($urandom);
         pl  = rand_payload((p % 3 == 0) ? 8 * $urandom_range(1, 8) : $urandom_range(1, 100));
         f   = make_frame(typ, pl, 1'b0);
         send_bytes(f, f.size());
         idle(15);
         expect_good(typ, pl, 1'b0);
         compare($sformatf("rand%0d", p));
      end
      tready_mode = 1;
      idle(5);

      check("axi_stable", 64'(stable_viol), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
